// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port register file with a per-register busy scoreboard.
// - Register 0 always reads as zero and is never marked busy.
// - With BYPASS=1, a read port whose address matches a write in the same cycle
//   returns that write data and reports ready.
// - Decode reserves a destination register (sets busy).
// - Writeback stores the data and releases the register.
//   If the same register is also reserved in that cycle, the reserve wins.
module regfile_mp_sb #(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_RD*AW-1:0]  rd_addr,
    output logic [NUM_RD*DW-1:0]  rd_data,
    output logic [NUM_RD-1:0]     rd_ready,
    input  logic                  we,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic [(2**AW)-1:0]    busy_vec,
    output logic                  busy_any
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic        BYP   = (BYPASS != 0);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             rsv_ok;

    assign wr_ok  = we && (wr_addr != '0);
    assign rsv_ok = rsv_en && (rsv_addr != '0);

    // Scoreboard next state.
    // The release from a write is applied first, then the reserve is applied on
    // top of it, so a reserve to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Register storage and scoreboard.
    // Everything is cleared asynchronously on reset, so reads never return X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
        end
    end

    // Read ports are independent of each other.
    // The bypass is gated by rst_n so that reads stay at zero while reset is held.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = rd_addr[i*AW +: AW];
        assign hit  = BYP && rst_n && wr_ok && (wr_addr == addr);

        assign rd_data[i*DW +: DW] = (addr == '0) ? '0      :
                                     hit          ? wr_data : mem_q[addr];
        assign rd_ready[i]         = (addr == '0) || hit || !busy_q[addr];
    end

    assign busy_vec = busy_q;
    assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb.
// Two instances share all inputs:
// - dut_b is built with the write-to-read bypass enabled.
// - dut_n is built with the bypass disabled.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  rdy_b, rdy_n;
    logic [31:0] busy_b, busy_n;
    logic        any_b, any_n;

    int passed = 0;
    int total  = 0;

    regfile_mp_sb #(.DW(32), .AW(5), .NUM_RD(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdata_b),
        .rd_ready(rdy_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_b), .busy_any(any_b)
    );

    regfile_mp_sb #(.DW(32), .AW(5), .NUM_RD(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdata_n),
        .rd_ready(rdy_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_n), .busy_any(any_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we       = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    initial begin
        idle();
        rst_n   = 1'b0;

        // Reset state, read ports at 5 and 31.
        rd_addr = {5'd31, 5'd5};
        #2;
        chk("rst_data_b", rdata_b, 64'h0);
        chk("rst_data_n", rdata_n, 64'h0);
        chk("rst_ready", {rdy_b, rdy_n}, 4'b1111);
        chk("rst_busy", {any_b, any_n, busy_b, busy_n}, 66'h0);

        // Reset state, both read ports at 0.
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("rst_r0", {rdata_b, rdy_b}, {64'h0, 2'b11});

        tick();
        rst_n = 1'b1;
        tick();

        // Write r7, then read it back on the next cycle.
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        chk("wr_r7_b", rdata_b[31:0], 32'hDEADBEEF);
        chk("wr_r7_n", rdata_n[31:0], 32'hDEADBEEF);

        // A write to r0 is ignored.
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rd_addr = {5'd0, 5'd0};
        #1;
        chk("wr_r0_bypass", rdata_b[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("wr_r0_b", rdata_b[31:0], 32'h0);
        chk("wr_r0_n", rdata_n[31:0], 32'h0);

        // Bypass: r9 holds 0x11, then 0x22 is written to r9.
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        rd_addr = {5'd9, 5'd7};
        #1;
        chk("byp_pre_b", rdata_b[63:32], 32'h22);
        chk("byp_pre_n", rdata_n[63:32], 32'h11);
        chk("byp_port0", rdata_b[31:0], 32'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("byp_post_b", rdata_b[63:32], 32'h22);
        chk("byp_post_n", rdata_n[63:32], 32'h22);

        // Scoreboard: reserve r12.
        rsv_en = 1'b1; rsv_addr = 5'd12;
        tick();
        idle();
        rd_addr = {5'd7, 5'd12};
        #1;
        chk("sb_rdy_b", rdy_b, 2'b10);
        chk("sb_rdy_n", rdy_n, 2'b10);
        chk("sb_busy", busy_b, 32'h0000_1000);
        chk("sb_any", {any_b, any_n}, 2'b11);

        // Write r12 = 0x55 while r12 is busy.
        // Only the bypass build sees the data and reports ready before the edge.
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'h55;
        #1;
        chk("sb_wr_b", {rdata_b[31:0], rdy_b[0]}, {32'h55, 1'b1});
        chk("sb_wr_n", {rdata_n[31:0], rdy_n[0]}, {32'h0, 1'b0});
        tick();
        idle();
        #1;
        chk("sb_rel_busy", {busy_b, busy_n}, 64'h0);
        chk("sb_rel_rd", {rdata_n[31:0], rdy_n[0]}, {32'h55, 1'b1});

        // Reserve and write r3 in the same cycle: the data is stored and r3 stays busy.
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hAB;
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        idle();
        rd_addr = {5'd3, 5'd3};
        #1;
        chk("sim_data", {rdata_b, rdata_n}, {32'hAB, 32'hAB, 32'hAB, 32'hAB});
        chk("sim_rdy", {rdy_b, rdy_n}, 4'b0000);
        chk("sim_busy", busy_b, 32'h0000_0008);

        // Reserving r0 leaves the scoreboard unchanged.
        // Re-reserving r3 keeps its single busy bit set.
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        rsv_addr = 5'd3;
        tick();
        idle();
        #1;
        chk("rsv_r0", {busy_b, busy_n}, {32'h8, 32'h8});

        // One write to r3 releases it even though it was reserved twice.
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hCD;
        tick();
        idle();
        #1;
        chk("rel_once", busy_b, 32'h0);

        // Writing a register that is not busy leaves it not busy.
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        tick();
        idle();
        #1;
        chk("wr_nonbusy", busy_b, 32'h0);

        // Set up the mid-flight reset: r4 and r8 busy, both holding data.
        we = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        tick();
        wr_addr = 5'd8; wr_data = 32'h88;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd8;
        tick();
        idle();
        rd_addr = {5'd8, 5'd4};
        #1;
        chk("mf_busy", busy_b, 32'h0000_0110);
        chk("mf_data", rdata_n, {32'h88, 32'h44});

        // Pulse reset between edges while a write and a reserve are pending.
        #1;
        we = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rst_n = 1'b0;
        #1;
        chk("mf_rst_busy", {any_b, any_n, busy_b, busy_n}, 66'h0);
        chk("mf_rst_data", {rdata_b, rdata_n}, 128'h0);
        chk("mf_rst_rdy", {rdy_b, rdy_n}, 4'b1111);
        tick();
        chk("mf_rst_hold", {any_b, busy_b, rdata_b}, 97'h0);
        idle();
        rst_n = 1'b1;
        tick();

        // Earlier contents are gone after the reset.
        rd_addr = {5'd9, 5'd7};
        #1;
        chk("post_rst", {rdata_b, rdata_n}, 128'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-write, two-read MIPS register file.
- Clocked storage of 2**AW registers of DW bits, NUM_RD combinational read ports, one synchronous write port and a hardwired-zero register 0.
- Optional write-to-read bypass.
- Per-register busy scoreboard: decode reserves a destination, writeback releases it, and each read port reports whether its operand is ready. Sits between decode (reads, reserve) and writeback (write).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW].
- rd_data  out  NUM_RD*DW  read data; port i at bits [i*DW +: DW].
- rd_ready  out  NUM_RD  1 = port i operand valid (not busy, or bypassed).
- we  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- busy_vec  out  2**AW  current scoreboard, bit n = register n busy.
- busy_any  out  1  OR of busy_vec.

Behaviour:
- Reset (rst_n low, asynchronous): all registers cleared to 0; all busy bits cleared.
  - Consequence: rd_data = 0, rd_ready = all ones, busy_vec = 0, busy_any = 0 while reset is held.
  - Deassertion takes effect at the next rising edge.
- Write: on a rising edge with we=1 and wr_addr != 0, mem[wr_addr] <= wr_data. Writes to address 0 are ignored.
- Read: combinational, zero latency.
  - Address 0 always returns 0 with rd_ready=1, regardless of bypass or scoreboard.
  - Otherwise rd_data = mem[addr] and rd_ready = ~busy[addr].
- Bypass, BYPASS=1: when we=1, wr_addr == rd_addr[i] and wr_addr != 0:
  - rd_data[i] = wr_data and rd_ready[i] = 1 in the same cycle, even if the register is busy.
  - With BYPASS=0, the new value is visible from the cycle after the write edge; rd_ready stays governed by the busy bit until that edge.
- Scoreboard, updated on each rising edge:
  - we=1, wr_addr != 0: busy[wr_addr] <= 0.
  - rsv_en=1, rsv_addr != 0: busy[rsv_addr] <= 1.
  - Same address in both: reserve wins, so busy stays/becomes 1 (newer producer), and wr_data is still stored.
  - Reserving an already-busy register: stays busy (single bit, no count).
  - Writing a non-busy register: legal, busy stays 0.
  - Reserve or write of register 0: no effect on busy; busy[0] is constant 0.
- Multiple read ports may use the same address; each port is fully independent.
- Reset mid-operation: all state cleared immediately, regardless of any pending we/rsv_en.
- No X propagation: all storage is reset, so every read after reset is defined.
- Target 120-400 lines of RTL: generate loops over ports, packed scoreboard vector, no latches.

Test Plan:
- Reset then read: assert rst_n=0, read addrs 0,5,31 on all ports -> rd_data=0, rd_ready=1, busy_any=0.
- Write/readback: write 0xDEADBEEF to r7, next cycle rd_addr0=7 -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0.
- Bypass (BYPASS=1): r9=0x11 stored; same cycle we=1, wr_addr=9, wr_data=0x22, rd_addr1=9 -> rd_data1=0x22 before the edge.
  - Repeat with BYPASS=0 -> 0x11 before the edge, 0x22 after.
- Scoreboard flow: rsv r12 -> next cycle rd_ready=0 on port reading 12, busy_vec[12]=1. Write r12=0x55 -> bypassed read ready in the write cycle, busy clear after the edge.
- Simultaneous reserve and write r3 -> after the edge mem[3] = wr_data, busy[3]=1. rsv r0 -> busy_vec unchanged.
- Async reset mid-flight: busy r4, r8 with data written, pulse rst_n low between edges -> immediate busy_vec=0 and all reads 0.
